// File: rtl/dp_latency_probe.sv
// dp_latency_probe
// Measures the register latency of an external datapath chain. The probe
// holds the chain input steady long enough to flush it, records the settled
// output level as a baseline, toggles the input, and counts cycles until the
// output leaves the baseline. This repeats NUM_RUNS times with alternating
// step polarity. The probe then reports the min, max and last latency.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE. A
// start seen in any other state is dropped, and no request is queued. busy is
// high from the cycle after acceptance through the DONE cycle. done is a
// one-cycle pulse in DONE, and all result outputs are valid during that pulse.
// The results then hold until the next start is accepted.
module dp_latency_probe #(
    parameter int FLUSH_CYCLES = 64,
    parameter int TIMEOUT      = 255,
    parameter int NUM_RUNS     = 4,
    localparam int CNT_W       = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dp_in,
    input  logic             dp_out,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             stable,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [CNT_W-1:0] lat_last,
    output logic [2:0]       dbg_state
);

    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int RUN_W  = $clog2(NUM_RUNS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_STEP    = 3'd2,
        S_MEASURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [FCNT_W-1:0]  r_fcnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [RUN_W-1:0]   r_run;
    logic [CNT_W-1:0]   r_min;
    logic [CNT_W-1:0]   r_max;
    logic               r_base;
    logic               r_dp_in;
    logic               r_timeout;
    logic               r_stable;
    logic [CNT_W-1:0]   r_lat_min;
    logic [CNT_W-1:0]   r_lat_max;
    logic [CNT_W-1:0]   r_lat_last;

    logic               w_flush_last;
    logic               w_changed;
    logic               w_cnt_max;
    logic [RUN_W-1:0]   w_run_inc;
    logic               w_last_run;
    logic [CNT_W-1:0]   w_min_nxt;
    logic [CNT_W-1:0]   w_max_nxt;

    // The conditions that steer both the FSM and the datapath registers.
    // An inverting chain is handled naturally because the baseline is the
    // settled output level rather than the input level.
    always_comb begin
        w_flush_last = (r_fcnt == FCNT_W'(FLUSH_CYCLES - 1));
        w_changed    = (dp_out != r_base);
        w_cnt_max    = (r_cnt == CNT_W'(TIMEOUT));
        w_run_inc    = r_run + RUN_W'(1);
        w_last_run   = (w_run_inc == RUN_W'(NUM_RUNS));
        w_min_nxt    = (r_cnt < r_min) ? r_cnt : r_min;
        w_max_nxt    = (r_cnt > r_max) ? r_cnt : r_max;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_last) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                if (w_changed) begin
                    w_state_nxt = w_last_run ? S_DONE : S_FLUSH;
                end else if (w_cnt_max) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, baseline capture, input drive and result registers.
    // The published min/max/stable values are loaded on the edge that enters
    // DONE, so they are already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt     <= '0;
            r_cnt      <= '0;
            r_run      <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_base     <= 1'b0;
            r_dp_in    <= 1'b0;
            r_timeout  <= 1'b0;
            r_stable   <= 1'b0;
            r_lat_min  <= '0;
            r_lat_max  <= '0;
            r_lat_last <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_timeout  <= 1'b0;
                        r_stable   <= 1'b0;
                        r_run      <= '0;
                        r_fcnt     <= '0;
                        r_min      <= '1;
                        r_max      <= '0;
                        r_lat_min  <= '0;
                        r_lat_max  <= '0;
                        r_lat_last <= '0;
                    end
                end
                S_FLUSH: begin
                    // Only the final-cycle sample becomes the baseline. Earlier
                    // toggles are the chain draining and are not an error.
                    if (w_flush_last) begin
                        r_base <= dp_out;
                        r_fcnt <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + FCNT_W'(1);
                    end
                end
                S_STEP: begin
                    r_dp_in <= ~r_dp_in;
                    r_cnt   <= '0;
                end
                S_MEASURE: begin
                    if (w_changed) begin
                        r_lat_last <= r_cnt;
                        r_min      <= w_min_nxt;
                        r_max      <= w_max_nxt;
                        r_run      <= w_run_inc;
                        if (w_last_run) begin
                            r_lat_min <= w_min_nxt;
                            r_lat_max <= w_max_nxt;
                            r_stable  <= (w_min_nxt == w_max_nxt);
                        end
                    end else if (w_cnt_max) begin
                        // Abort. Publish only the runs that completed. With
                        // none completed, the internal min is still all-ones,
                        // so report zero instead.
                        r_timeout <= 1'b1;
                        r_stable  <= 1'b0;
                        if (r_run == '0) begin
                            r_lat_min <= '0;
                            r_lat_max <= '0;
                        end else begin
                            r_lat_min <= r_min;
                            r_lat_max <= r_max;
                        end
                    end else begin
                        // The w_cnt_max branch above catches TIMEOUT, so the
                        // counter saturates there and never wraps.
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dp_in     = r_dp_in;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign timeout   = r_timeout;
    assign stable    = r_stable;
    assign lat_min   = r_lat_min;
    assign lat_max   = r_lat_max;
    assign lat_last  = r_lat_last;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dp_latency_probe.sv
// Bench for dp_latency_probe. A bench-side model chain sits between dp_in and
// dp_out, selected per scenario: a wire, a 5-flop shift, an inverter plus 3
// flops, a constant 0, or a path whose latency alternates 2/4 with step polarity.
module tb_dp_latency_probe;

  localparam int FLUSH = 16;
  localparam int TMO   = 15;
  localparam int RUNS  = 4;
  localparam int CW    = 4;
  localparam int W     = 3 * CW + 3;
  localparam logic [2:0] ST_MEAS = 3'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          dp_in;
  logic          dp_out;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          stable;
  logic [CW-1:0] lat_min;
  logic [CW-1:0] lat_max;
  logic [CW-1:0] lat_last;
  logic [2:0]    dbg_state;

  int            total = 0;
  int            bad = 0;
  logic [W-1:0]  exp_q[$];
  int            mode = 0;
  logic [4:0]    sh = '0;
  logic          exp_dpin = 1'b0;

  dp_latency_probe #(
    .FLUSH_CYCLES(FLUSH),
    .TIMEOUT(TMO),
    .NUM_RUNS(RUNS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dp_in(dp_in),
    .dp_out(dp_out),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .stable(stable),
    .lat_min(lat_min),
    .lat_max(lat_max),
    .lat_last(lat_last),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model chain
  always @(posedge clk) sh <= {sh[3:0], dp_in};

  always_comb begin
    case (mode)
      0:       dp_out = dp_in;
      1:       dp_out = sh[4];
      2:       dp_out = ~sh[2];
      3:       dp_out = 1'b0;
      4:       dp_out = dp_in ? sh[1] : sh[3];
      default: dp_out = dp_in;
    endcase
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one start, push the expected result, then pop and compare it at done.
  task automatic run_seq(input string name, input logic [CW-1:0] e_min, input logic [CW-1:0] e_max,
                         input logic [CW-1:0] e_last, input logic e_stb, input logic e_tmo,
                         input int e_meas, input int e_tog, input bit poke_busy);
    logic [W-1:0] e;
    logic         e_dp_end;
    logic         prev;
    int           cyc;
    int           tog;
    int           first;
    int           meas;
    bit           seen;
    e_dp_end = exp_dpin ^ e_tog[0];
    exp_q.push_back({e_tmo, e_stb, e_dp_end, e_last, e_max, e_min});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_start"}, busy, 1);
    check({name, "_tmo_clear"}, timeout, 0);
    prev = dp_in;
    cyc = 0; tog = 0; first = 0; meas = 0; seen = 0;
    while (cyc < 2000 && !seen) begin
      @(negedge clk);
      cyc++;
      start = (poke_busy && cyc == 30);
      if (dp_in !== prev) begin
        tog++;
        if (first == 0) first = cyc;
        prev = dp_in;
      end
      if (dbg_state == ST_MEAS) meas++;
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    check({name, "_done_seen"}, seen, 1);
    if (seen) begin
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
        check({name, "_lat_min"}, lat_min, e[CW-1:0]);
        check({name, "_lat_max"}, lat_max, e[2*CW-1:CW]);
        check({name, "_lat_last"}, lat_last, e[3*CW-1:2*CW]);
        check({name, "_dp_in_end"}, dp_in, e[3*CW]);
        check({name, "_stable"}, stable, e[3*CW+1]);
        check({name, "_timeout"}, timeout, e[3*CW+2]);
        check({name, "_busy_in_done"}, busy, 1);
      end
      check({name, "_first_step"}, first, FLUSH + 1);
      check({name, "_toggles"}, tog, e_tog);
      check({name, "_meas_cycles"}, meas, e_meas);
      @(negedge clk);
      check({name, "_done_pulse"}, done, 0);
      check({name, "_busy_after"}, busy, 0);
      check({name, "_hold_last"}, lat_last, e_last);
    end
    exp_dpin = e_dp_end;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dp_in"}, dp_in, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_timeout"}, timeout, 0);
    check({name, "_stable"}, stable, 0);
    check({name, "_lat_min"}, lat_min, 0);
    check({name, "_lat_max"}, lat_max, 0);
    check({name, "_lat_last"}, lat_last, 0);
    check({name, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int cyc;
    int tog;
    logic prev;
    rst = 1'b1;
    start = 1'b0;
    idle_cycles(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle_cycles(2);
    check_all_zero("post_reset");

    // wire loopback
    mode = 0;
    run_seq("wire", 0, 0, 0, 1, 0, 4, 4, 0);
    idle_cycles(2);

    // 5-flop shift register
    mode = 1;
    run_seq("shift5", 5, 5, 5, 1, 0, 24, 4, 0);
    idle_cycles(2);

    // inverter plus 3 flops
    mode = 2;
    run_seq("inv3", 3, 3, 3, 1, 0, 16, 4, 0);
    idle_cycles(2);

    // alternating 2/4 latency, with a start pulsed while busy
    mode = 4;
    run_seq("alt24", 2, 4, 4, 0, 0, 16, 4, 1);
    idle_cycles(3);
    check("alt24_still_idle", busy, 0);

    // async reset during MEASURE of run 2
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = dp_in;
    cyc = 0; tog = 0;
    while (cyc < 500 && tog < 3) begin
      @(negedge clk);
      cyc++;
      if (dp_in !== prev) begin
        tog++;
        prev = dp_in;
      end
    end
    check("mid_run_reach", tog, 3);
    @(negedge clk);
    check("mid_run_in_measure", dbg_state, ST_MEAS);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_dpin = 1'b0;
    idle_cycles(2);
    run_seq("shift5_again", 5, 5, 5, 1, 0, 24, 4, 0);
    idle_cycles(2);

    // timeout with dp_out tied low, from a fresh reset
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    exp_dpin = 1'b0;
    idle_cycles(2);
    mode = 3;
    run_seq("tmo", 0, 0, 0, 0, 1, TMO + 1, 1, 0);
    idle_cycles(4);
    check("tmo_sticky", timeout, 1);
    mode = 0;
    run_seq("after_tmo", 0, 0, 0, 1, 0, 4, 4, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
